// File: rtl/stream_ahb_writer.sv
// AHB-Lite master that packs a 16-bit sample stream two-per-word and writes single words from a base address.
// A frame ends on tlast or on the word limit; done then pulses for one cycle.
module stream_ahb_writer #(
  parameter int AW = 32,
  parameter int CW = 12
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          start,
  input  logic [AW-1:0] cfg_base,
  input  logic [CW-1:0] cfg_words,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] words_written,
  input  logic [15:0]   tdata_s,
  input  logic          tlast_s,
  input  logic          tvalid_s,
  output logic          tready_s,
  output logic [AW-1:0] haddr_m,
  output logic [1:0]    htrans_m,
  output logic [2:0]    hsize_m,
  output logic [2:0]    hburst_m,
  output logic          hwrite_m,
  output logic [31:0]   hwdata_m,
  input  logic          hready_m,
  input  logic          hresp_m
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ADDR, S_DATA, S_DRAIN, S_DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] base_q, haddr_q;
  logic [CW-1:0] limit_q, cnt_q;
  logic [1:0]    htrans_q;
  logic [31:0]   hwdata_q, wbuf_q;
  logic [15:0]   lo_q;
  logic          err_q, hwrite_q, half_q, wbuf_full_q, wbuf_last_q, cur_last_q, last_seen_q;

  logic          packing, accept, last_any;
  logic [CW-1:0] cnt_inc, ld_cnt;
  logic [AW-1:0] load_addr;

  assign packing   = state_q inside {S_FILL, S_ADDR, S_DATA};
  // Once tlast has been packed, stop accepting so the next frame's samples stay upstream.
  assign tready_s  = packing ? (!wbuf_full_q && !last_seen_q) : (state_q == S_DRAIN);
  assign accept    = tvalid_s && tready_s;
  assign last_any  = last_seen_q || (accept && tlast_s);
  assign cnt_inc   = cnt_q + CW'(1);
  assign ld_cnt    = (state_q == S_DATA) ? cnt_inc : cnt_q;
  assign load_addr = base_q + (AW'(ld_cnt) << 2);

  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign words_written = cnt_q;
  assign haddr_m       = haddr_q;
  assign htrans_m      = htrans_q;
  assign hwrite_m      = hwrite_q;
  assign hwdata_m      = hwdata_q;
  assign hsize_m       = 3'b010;
  assign hburst_m      = 3'b000;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      limit_q     <= '0;
      cnt_q       <= '0;
      haddr_q     <= '0;
      htrans_q    <= 2'b00;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      wbuf_q      <= '0;
      lo_q        <= '0;
      err_q       <= 1'b0;
      half_q      <= 1'b0;
      wbuf_full_q <= 1'b0;
      wbuf_last_q <= 1'b0;
      cur_last_q  <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      if (packing && accept) begin
        if (!half_q && tlast_s) begin
          wbuf_q      <= {16'h0000, tdata_s};
          wbuf_full_q <= 1'b1;
          wbuf_last_q <= 1'b1;
        end else if (!half_q) begin
          lo_q   <= tdata_s;
          half_q <= 1'b1;
        end else begin
          wbuf_q      <= {tdata_s, lo_q};
          wbuf_full_q <= 1'b1;
          wbuf_last_q <= tlast_s;
          half_q      <= 1'b0;
        end
        if (tlast_s) last_seen_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q      <= cfg_base & {{(AW-2){1'b1}}, 2'b00};
            limit_q     <= cfg_words;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            half_q      <= 1'b0;
            wbuf_full_q <= 1'b0;
            last_seen_q <= 1'b0;
            state_q     <= (cfg_words == '0) ? S_DRAIN : S_FILL;
          end
        end
        S_FILL: begin
          if (wbuf_full_q) begin
            hwdata_q    <= wbuf_q;
            cur_last_q  <= wbuf_last_q;
            wbuf_full_q <= 1'b0;
            haddr_q     <= load_addr;
            htrans_q    <= 2'b10;
            hwrite_q    <= 1'b1;
            state_q     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (hready_m) begin
            htrans_q <= 2'b00;
            hwrite_q <= 1'b0;
            state_q  <= S_DATA;
          end
        end
        S_DATA: begin
          if (hready_m) begin
            if (hresp_m) begin
              err_q   <= 1'b1;
              state_q <= (cur_last_q || last_any) ? S_DONE : S_DRAIN;
            end else begin
              cnt_q <= cnt_inc;
              if (cur_last_q) begin
                state_q <= S_DONE;
              end else if (cnt_inc == limit_q) begin
                // tlast may already sit in the buffer; draining would then wait forever.
                state_q <= last_any ? S_DONE : S_DRAIN;
              end else if (wbuf_full_q) begin
                hwdata_q    <= wbuf_q;
                cur_last_q  <= wbuf_last_q;
                wbuf_full_q <= 1'b0;
                haddr_q     <= load_addr;
                htrans_q    <= 2'b10;
                hwrite_q    <= 1'b1;
                state_q     <= S_ADDR;
              end else begin
                state_q <= S_FILL;
              end
            end
          end
        end
        S_DRAIN: begin
          if (accept && tlast_s) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_ahb_writer.sv
// Bench for stream_ahb_writer: table of frames checked against a write scoreboard, plus a reset-in-ADDR sequence.
module tb_stream_ahb_writer;
  localparam int AW = 32;
  localparam int CW = 12;

  logic          hclk = 1'b0;
  logic          hreset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [CW-1:0] cfg_words = '0;
  logic          busy, done, err;
  logic [CW-1:0] words_written;
  logic [15:0]   tdata_s = '0;
  logic          tlast_s = 1'b0;
  logic          tvalid_s = 1'b0;
  logic          tready_s;
  logic [AW-1:0] haddr_m;
  logic [1:0]    htrans_m;
  logic [2:0]    hsize_m, hburst_m;
  logic          hwrite_m;
  logic [31:0]   hwdata_m;
  logic          hready_m = 1'b1;
  logic          hresp_m = 1'b0;

  always #5 hclk = ~hclk;

  stream_ahb_writer #(.AW(AW), .CW(CW)) dut (
    .hclk(hclk), .hreset(hreset), .start(start), .cfg_base(cfg_base), .cfg_words(cfg_words),
    .busy(busy), .done(done), .err(err), .words_written(words_written),
    .tdata_s(tdata_s), .tlast_s(tlast_s), .tvalid_s(tvalid_s), .tready_s(tready_s),
    .haddr_m(haddr_m), .htrans_m(htrans_m), .hsize_m(hsize_m), .hburst_m(hburst_m),
    .hwrite_m(hwrite_m), .hwdata_m(hwdata_m), .hready_m(hready_m), .hresp_m(hresp_m)
  );

  typedef struct {
    logic [31:0] base;
    int          words;
    int          nsamp;
    logic [15:0] seed;
    logic [15:0] step;
    int          stall_a;
    int          stall_d;
    int          err_wr;
    int          exp_ww;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  int          tests = 0, fails = 0, cyc = 0;
  int          stall_a = 0, stall_d = 0, err_wr = -1, wr_idx = 0, acnt = 0, dcnt = 0;
  bit          dphase = 0, prev_a = 0, prev_d = 0;
  logic [31:0] prev_addr, prev_data, cur_addr;
  int          done_cnt = 0, done_cyc = 0, tr_low = 0, n_wr = 0, hs_cnt = 0, hs_last = 0;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge hclk) cyc++;

  // AHB slave model and bus monitor; decides hready/hresp for the coming edge.
  always @(negedge hclk) begin
    if (hreset) begin
      dphase = 0; prev_a = 0; prev_d = 0; acnt = 0; dcnt = 0;
      hready_m = 1'b1; hresp_m = 1'b0;
    end else begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy && tvalid_s && !tready_s) tr_low++;
      if (prev_a) begin
        check("addr_stable", haddr_m, prev_addr);
        check("htrans_stable", {30'd0, htrans_m}, 32'd2);
      end
      if (prev_d) check("wdata_stable", hwdata_m, prev_data);
      prev_a = 0; prev_d = 0;
      hready_m = 1'b1; hresp_m = 1'b0;
      if (dphase) begin
        if (dcnt < stall_d) hready_m = 1'b0;
        else if (wr_idx == err_wr) begin
          hresp_m  = 1'b1;
          hready_m = (dcnt > stall_d);
        end
        dcnt++;
        if (hready_m) begin
          n_wr++; wr_idx++; dphase = 0;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got 0x%08h@0x%08h expected none", hwdata_m, cur_addr);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", cur_addr, e.addr);
            check("wr_data", hwdata_m, e.data);
          end
        end else begin
          prev_d = 1; prev_data = hwdata_m;
        end
      end else if (htrans_m == 2'b10) begin
        hready_m = (acnt >= stall_a);
        acnt++;
        if (hready_m) begin
          dphase = 1; dcnt = 0; acnt = 0; cur_addr = haddr_m;
          check("hwrite_in_addr", {31'd0, hwrite_m}, 32'd1);
        end else begin
          prev_a = 1; prev_addr = haddr_m;
        end
      end
    end
  end

  task automatic send(input vec_t v);
    int t;
    for (int k = 0; k < v.nsamp; k++) begin
      tvalid_s = 1'b1;
      tdata_s  = v.seed + 16'(k) * v.step;
      tlast_s  = (k == v.nsamp - 1);
      t = 0;
      @(negedge hclk);
      while (!tready_s && t < 500) begin t++; @(negedge hclk); end
      if (!tready_s) begin
        tests++; fails++;
        $display("FAIL stream_timeout: sample %0d not accepted, expected acceptance", k);
        tvalid_s = 1'b0; tlast_s = 1'b0;
        return;
      end
      hs_cnt++; hs_last = cyc + 1;
      @(posedge hclk); #1;
    end
    tvalid_s = 1'b0; tlast_s = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    int          nwr, t;
    logic [15:0] lo, hi;
    wr_t         w2;
    exp_q.delete();
    stall_a = v.stall_a; stall_d = v.stall_d; err_wr = v.err_wr; wr_idx = 0;
    done_cnt = 0; tr_low = 0; n_wr = 0; hs_cnt = 0; hs_last = 0;
    nwr = (v.nsamp + 1) / 2;
    if (nwr > v.words) nwr = v.words;
    if (v.err_wr >= 0 && nwr > v.err_wr + 1) nwr = v.err_wr + 1;
    for (int w = 0; w < nwr; w++) begin
      lo = v.seed + 16'(2 * w) * v.step;
      hi = (2 * w + 1 < v.nsamp) ? v.seed + 16'(2 * w + 1) * v.step : 16'h0000;
      w2.addr = (v.base & 32'hFFFF_FFFC) + 32'(4 * w);
      w2.data = {hi, lo};
      exp_q.push_back(w2);
    end
    @(posedge hclk); #1;
    start = 1'b1; cfg_base = v.base; cfg_words = CW'(v.words);
    @(posedge hclk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("err_cleared", {31'd0, err}, 32'd0);
    check("ww_cleared", 32'(words_written), 32'd0);
    send(v);
    t = 0;
    while (done_cnt == 0 && t < 1000) begin @(negedge hclk); #1; t++; end
    check("done_seen", 32'(done_cnt > 0), 32'd1);
    repeat (4) @(posedge hclk);
    #1;
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("done_after_last_beat", 32'(done_cyc >= hs_last), 32'd1);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("words_written", 32'(words_written), 32'(v.exp_ww));
    check("err_flag", {31'd0, err}, {31'd0, v.exp_err});
    check("write_count", 32'(n_wr), 32'(nwr));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("samples_accepted", 32'(hs_cnt), 32'(v.nsamp));
    if (v.stall_a > 0) check("tready_backpressure", 32'(tr_low > 0), 32'd1);
  endtask

  initial begin
    int   t;
    vec_t v;
    // base, words, nsamp, seed, step, stall_a, stall_d, err_wr, exp_ww, exp_err
    vecs[0] = '{32'h2000_0000, 4, 8,  16'h0001, 16'h0001, 0, 0, -1, 4, 1'b0};
    vecs[1] = '{32'h2000_0100, 8, 3,  16'hAAAA, 16'h1111, 0, 0, -1, 2, 1'b0};
    vecs[2] = '{32'h2000_0200, 2, 10, 16'h0100, 16'h0001, 0, 0, -1, 2, 1'b0};
    vecs[3] = '{32'h2000_0300, 8, 8,  16'h5000, 16'h0003, 3, 3, -1, 4, 1'b0};
    vecs[4] = '{32'h2000_0400, 4, 8,  16'h0010, 16'h0001, 0, 0, 1,  1, 1'b1};
    vecs[5] = '{32'h2000_0500, 4, 4,  16'h7000, 16'h0002, 1, 0, -1, 2, 1'b0};
    vecs[6] = '{32'hFFFF_FFFB, 4, 8,  16'h9000, 16'h0001, 0, 1, -1, 4, 1'b0};
    vecs[7] = '{32'h2000_0600, 0, 5,  16'h0001, 16'h0001, 0, 0, -1, 0, 1'b0};
    vecs[8] = '{32'h2000_0700, 4, 2,  16'h1234, 16'h0001, 0, 0, 0,  0, 1'b1};

    #1;
    check("rst_htrans", {30'd0, htrans_m}, 32'd0);
    check("rst_haddr", haddr_m, 32'd0);
    check("rst_hwdata", hwdata_m, 32'd0);
    check("rst_hwrite", {31'd0, hwrite_m}, 32'd0);
    check("rst_tready", {31'd0, tready_s}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ww", 32'(words_written), 32'd0);
    check("hsize_const", {29'd0, hsize_m}, 32'd2);
    check("hburst_const", {29'd0, hburst_m}, 32'd0);
    repeat (2) @(negedge hclk);
    #2 hreset = 1'b0;

    tvalid_s = 1'b1; tdata_s = 16'hDEAD;
    repeat (3) @(posedge hclk);
    #1;
    check("idle_tready_low", {31'd0, tready_s}, 32'd0);
    tvalid_s = 1'b0;

    for (int i = 0; i < 9; i++) run_case(vecs[i]);

    // Reset while the address phase is stalled.
    stall_a = 100000; err_wr = -1; exp_q.delete();
    @(posedge hclk); #1;
    start = 1'b1; cfg_base = 32'h3000_0000; cfg_words = CW'(4);
    @(posedge hclk); #1;
    start = 1'b0;
    tvalid_s = 1'b1; tdata_s = 16'h1111; tlast_s = 1'b0;
    t = 0;
    @(negedge hclk); #1;
    while (htrans_m != 2'b10 && t < 100) begin @(negedge hclk); #1; t++; end
    check("reached_addr", {30'd0, htrans_m}, 32'd2);
    #1 hreset = 1'b1;
    #1;
    check("arst_htrans", {30'd0, htrans_m}, 32'd0);
    check("arst_tready", {31'd0, tready_s}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hwrite", {31'd0, hwrite_m}, 32'd0);
    tvalid_s = 1'b0;
    repeat (2) @(negedge hclk);
    #2 hreset = 1'b0;
    v = '{32'h3000_0000, 2, 4, 16'h4000, 16'h0001, 0, 0, -1, 2, 1'b0};
    run_case(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/stream_ahb_writer.md
Name: stream_ahb_writer

Overview:
- AHB-Lite master DMA writer. It drains the 16-bit AXI-Stream spectrum output of the DSP chain into system memory.
- Samples are packed two per 32-bit word, low halfword first, and written with single word transfers from a programmed base address.
- A frame ends on tlast or when the word limit is reached. The block then raises a done pulse for the interrupt controller.
- It is the initiator side of the bus that the DSP subsystem answers as a slave.

Parameters:
- AW, 32, AHB address width.
- CW, 12, width of the word limit and word counter.

Ports:
- hclk  in  1  system clock; all logic rising-edge.
- hreset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a frame capture. Ignored while busy.
- cfg_base  in  AW  destination base address; bits [1:0] ignored (word aligned). Sampled on start.
- cfg_words  in  CW  maximum words per frame; sampled on start.
- busy  out  1  high from accepted start until DONE.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  sticky bus-error flag; cleared on next accepted start.
- words_written  out  CW  successful writes in current/last frame.
- tdata_s  in  16  stream sample.
- tlast_s  in  1  last sample of frame.
- tvalid_s  in  1  stream valid.
- tready_s  out  1  stream ready.
- haddr_m  out  AW  AHB address.
- htrans_m  out  2  IDLE=00 or NONSEQ=10 only.
- hsize_m  out  3  constant 3'b010 (word).
- hburst_m  out  3  constant 3'b000 (SINGLE).
- hwrite_m  out  1  1 during NONSEQ, else 0.
- hwdata_m  out  32  write data.
- hready_m  in  1  AHB HREADY.
- hresp_m  in  1  AHB HRESP (1=ERROR).

Behaviour:
- Reset values: htrans_m=00, haddr_m=0, hwdata_m=0, hwrite_m=0, tready_s=0, busy=0, done=0, err=0, words_written=0. Internal word buffer is empty and the half flag is clear.
- Reset mid-transfer forces htrans_m to IDLE asynchronously. The partial frame is discarded.
- States: IDLE, FILL, ADDR, DATA, DRAIN, DONE.
- IDLE:
  - tready_s=0.
  - On start, latch base/limit, clear err and counter, set busy.
  - If cfg_words=0, go to DRAIN; otherwise go to FILL.
- Packing (active in FILL/ADDR/DATA):
  - tready_s = !wbuf_full.
  - The first accepted sample goes to the low half.
  - The second accepted sample, or tlast on the first, completes the word into wbuf. The high half is zero if tlast falls on the low half. wlast is recorded.
- FILL: when wbuf full, load hwdata staging from wbuf, free wbuf, go to ADDR.
- ADDR:
  - Drive htrans_m=NONSEQ, hwrite_m=1, haddr_m=base+4*words_written.
  - Hold all signals stable until hready_m=1, then go to DATA.
- DATA:
  - htrans_m=IDLE; hwdata_m holds the word until hready_m=1.
  - Packing continues into wbuf during ADDR and DATA.
- DATA completion (hready_m=1, hresp_m=0):
  - Increment words_written.
  - If the word carried wlast, go to DONE.
  - Else if words_written+1 == limit, go to DRAIN.
  - Else if wbuf full, load it and go straight to ADDR; else go to FILL.
- DATA error (hready_m=1, hresp_m=1, final cycle of the two-cycle error response):
  - Set err; the counter is not incremented.
  - If the word carried wlast, go to DONE; else go to DRAIN.
  - No retry. The first error cycle (hready_m=0) simply waits; htrans is already IDLE, so the protocol is met.
- DRAIN:
  - tready_s=1; samples are accepted and dropped.
  - Any pending wbuf/partial word is discarded.
  - On an accepted beat with tlast_s=1, go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE. words_written and err hold until next start.
- Minimum write cost is 2 cycles (ADDR+DATA) per word, plus 1 cycle via FILL when the buffer is empty. At 1 sample/cycle input, tready_s deasserts when wbuf is full.
- Address arithmetic wraps modulo 2^AW; no boundary checks.
- start while busy is ignored. tvalid_s during IDLE is not accepted (tready_s=0).

Test Plan:
- Basic frame:
  - Stimulus: cfg_base=0x2000_0000, cfg_words=4; samples 0x0001..0x0008, tlast on 0x0008, hready_m=1.
  - Required: writes 0x00020001@0x20000000, 0x00040003@0x20000004, 0x00060005@0x20000008, 0x00080007@0x2000000C; one done pulse; words_written=4; err=0.
- Odd tlast:
  - Stimulus: samples 0xAAAA, 0xBBBB, 0xCCCC with tlast on 0xCCCC; cfg_words=8.
  - Required: writes 0xBBBBAAAA then 0x0000CCCC; words_written=2; done.
- Limit hit:
  - Stimulus: cfg_words=2; 10 samples, tlast on 10th.
  - Required: exactly 2 writes; the remaining 6 samples accepted with tready_s=1 and dropped; done only after the tlast beat.
- Wait states:
  - Stimulus: hready_m low for 3 cycles in ADDR and in DATA; continuous tvalid_s.
  - Required: haddr_m, htrans_m, hwdata_m stable while stalled; tready_s drops once wbuf fills; no sample lost or duplicated.
- Bus error:
  - Stimulus: ERROR response on 2nd write of a 4-word frame.
  - Required: err=1; words_written=1; no further writes; drain to tlast; done pulse; next start clears err.
- Reset during ADDR:
  - Stimulus: assert hreset while in ADDR.
  - Required: htrans_m=00, tready_s=0, busy=0 immediately, without waiting for hclk. A new start after release writes from cfg_base with words_written=0.
